// File: rtl/debug_tx_fifo_pkg.sv
// Shared definitions between the pipeline debug unit and its UART transmit FIFO.
package debug_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_WAIT  = 2'b10
    } tx_state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

    // Terminator word the debug unit pushes at the end of a dump ("endd").
    localparam logic [31:0] ENDD_WORD = 32'h656E6464;

    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/debug_tx_fifo_if.sv
// Push-side and UART-side signals of debug_tx_fifo; slave is the FIFO, master the environment.
interface debug_tx_fifo_if
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    // Handshakes: a word is accepted at every rising edge where i_write_en=1 and o_full=0.
    // o_tx_start pulses one cycle with o_tx_byte, which stays stable until the one-cycle i_tx_done.
    logic                  i_write_en;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_full;
    logic                  o_empty;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_overflow;
    logic                  o_tx_start;
    logic [7:0]            o_tx_byte;
    logic                  i_tx_done;
    logic                  o_busy;
    tx_state_e             o_tx_state;

    modport slave (
        input  i_write_en, i_data, i_tx_done,
        output o_full, o_empty, o_count, o_overflow,
        output o_tx_start, o_tx_byte, o_busy, o_tx_state
    );

    modport master (
        output i_write_en, i_data, i_tx_done,
        input  o_full, o_empty, o_count, o_overflow,
        input  o_tx_start, o_tx_byte, o_busy, o_tx_state
    );

endinterface

// File: rtl/debug_tx_fifo_sync_fifo.sv
// Generic single-clock word FIFO with registered count/full/empty, sticky overflow and flush.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  do_push, do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    always_comb begin
        do_push    = wr_en && !full_q && !flush;
        do_pop     = rd_en && !empty_q && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d    = count_q + {{ADDR_WIDTH{1'b0}}, do_push}
                                 - {{ADDR_WIDTH{1'b0}}, do_pop};
            overflow_d = overflow_q || (wr_en && full_q);
        end
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/debug_tx_fifo.sv
// Buffers debug-unit words and serialises each one MSB-first into bytes for the UART transmitter.
module debug_tx_fifo
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    debug_tx_fifo_if.slave  bus
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full, fifo_empty, fifo_overflow;
    logic [ADDR_WIDTH:0]   fifo_count;

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_byte_q, tx_byte_d;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_reset),
        .flush    (i_flush),
        .wr_en    (bus.i_write_en),
        .wr_data  (bus.i_data),
        .rd_en    (fifo_pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_overflow)
    );

    // Start/byte are registered, so the pulse appears the cycle after TX_START is entered.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        fifo_pop   = 1'b0;
        if (i_flush) begin
            state_d = TX_IDLE;
            shift_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        idx_d    = '0;
                        state_d  = TX_START;
                    end
                end
                TX_START: begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = shift_q[DATA_WIDTH-1 -: 8];
                    state_d    = TX_WAIT;
                end
                TX_WAIT: begin
                    if (bus.i_tx_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = TX_IDLE;
                        end else begin
                            shift_d = shift_q << 8;
                            idx_d   = idx_q + 1'b1;
                            state_d = TX_START;
                        end
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign bus.o_full     = fifo_full;
    assign bus.o_empty    = fifo_empty;
    assign bus.o_count    = fifo_count;
    assign bus.o_overflow = fifo_overflow;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_byte  = tx_byte_q;
    assign bus.o_busy     = (state_q != TX_IDLE);
    assign bus.o_tx_state = state_q;

endmodule
